ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port 16-bit data RAM between two requesters: port 0 (CPU load/store path)
//  and port 1 (program loader / DMA). It registers the winner's address, data and MW onto the
//  RAM and captures read data with a per-port valid strobe. It rejects out-of-range addresses.
//  It sits between both requesters and the RAM's addr/data/MW/salida pins.
// PARAMETERS
//  DW         16   data width
//  AW         16   address width
//  DEPTH      126  RAM words; legal addresses 0..DEPTH-1
//  MAX_BURST  4    max consecutive locked grants to one port before forced re-arbitration
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous reset, active-high
//  req0       in   1   port 0 access request
//  we0        in   1   port 0 write (1) / read (0)
//  lock0      in   1   port 0 asks to keep grant for next access
//  addr0      in   AW  port 0 word address
//  wdata0     in   DW  port 0 write data
//  gnt0       out  1   port 0 request accepted (1-cycle pulse)
//  rvalid0    out  1   port 0 read data valid (1-cycle pulse)
//  rdata0     out  DW  port 0 read data, held until next port 0 read completes
//  err0       out  1   port 0 address out of range (1-cycle pulse)
//  req1..err1      as port 0, for port 1
//  ram_addr   out  AW  RAM address
//  ram_data   out  DW  RAM write data
//  ram_mw     out  1   RAM write enable (RAM commits on posedge when 1)
//  ram_rdata  in   DW  RAM combinational read data
// BEHAVIOUR
//  - Reset values: state=IDLE, every gnt/rvalid/err/ram_mw = 0, ram_addr/ram_data/rdata0/rdata1 = 0,
//    burst_cnt = 0, last_winner = 1. With last_winner = 1, port 0 wins the first tie.
//  - FSM has two states, IDLE and ACCESS. Arbitration happens on every edge, from either state.
//    - Any req at edge E: winner w is chosen. gnt_w=1, ram_addr=addr_w, ram_data=wdata_w and
//      ram_mw=we_w&in_range are registered. Next state is ACCESS.
//    - No req at edge E: next state is IDLE. All gnt are 0 and ram_mw is 0.
//  - Handshake:
//    - The requester holds req/we/addr/wdata stable until it sees gnt.
//    - req sampled during a cycle with gnt=1 is a NEW request. The requester drops req in that
//      cycle if it has no further access.
//  - ACCESS cycle: the RAM sees the registered address. A write commits at the edge that ends
//    ACCESS. At that edge, for a read: rdata_w<=ram_rdata and rvalid_w=1.
//    Latency: req -> gnt is 1 edge; gnt -> rvalid is 1 edge.
//  - Throughput: back-to-back accesses give one access per cycle.
//  - Writes produce no rvalid.
//  - Out of range (addr >= DEPTH):
//    - ram_mw is forced 0 and ram_addr is driven 0.
//    - gnt is still given. err_w pulses in the rvalid slot; rvalid stays 0 and rdata is unchanged.
//  - Lock: if winner w has req_w&lock_w at re-arbitration and burst_cnt < MAX_BURST-1, w wins again
//    regardless of the other port, and burst_cnt increments.
//    - When burst_cnt reaches the limit and the other port requests, the other port wins and
//      burst_cnt is cleared.
//    - burst_cnt also clears on any change of winner and on IDLE.
//  - Mid-operation reset: outputs drop asynchronously, so a write in ACCESS is NOT committed.
//    State returns to IDLE.
// CONFIGURATION
//  RAM_ARB_ROUND_ROBIN_EN defined: on an unlocked tie, the port != last_winner wins.
//  Undefined: on an unlocked tie, port 0 always wins (port 1 can starve). Lock and MAX_BURST
//  apply in both cases.
// STRUCTURE
//  Package ram_arb_pkg contains:
//    - state typedef {IDLE, ACCESS}
//    - port index constants P_CPU=0, P_LDR=1
//    - default DW/AW/DEPTH/MAX_BURST localparams
//  Sub-module ram_arb_pick: combinational winner select from req, lock, last_winner and
//  burst_cnt, with the macro applied inside it.
// TESTING
//  1. RAM[0]=32761; req0 read addr 0 at cycle 1 -> gnt0 cycle 2, rvalid0 cycle 3, rdata0=32761.
//  2. req1 write addr 5 data 16'h00AA, then req0 read addr 5 -> ram_mw high exactly 1 cycle;
//     rdata0=16'h00AA.
//  3. req0 and req1 held high, no lock -> with macro gnt alternates 0,1,0,1; without it gnt0
//     every cycle and gnt1 never.
//  4. lock1 and req1 held, req0 high, MAX_BURST=4 -> exactly 4 consecutive gnt1, then gnt0.
//  5. Write addr 126 -> ram_mw stays 0, err pulse, no rvalid. Write addr 125 -> committed, no err.
//  6. rst asserted mid-ACCESS of write to addr 3 -> ram_mw/gnt drop at once; RAM[3] unchanged;
//     IDLE after release.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the two-port data RAM arbiter.
package ram_arb_pkg;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam int unsigned P_CPU     = 0;
  localparam int unsigned P_LDR     = 1;
  localparam int unsigned DW        = 16;
  localparam int unsigned AW        = 16;
  localparam int unsigned DEPTH     = 126;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned BCW       = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the RAM arbiter (lock/burst aware).
// RAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority on unlocked ties.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0]     req,
  input  logic [1:0]     lock,
  input  logic           held,
  input  logic           last_winner,
  input  logic [BCW-1:0] burst_cnt,
  output logic           any_c,
  output logic           winner_c,
  output logic           locked_c,
  output logic           limit_c
);

  logic keep;

  always_comb begin
    any_c    = |req;
    winner_c = 1'b0;
    locked_c = 1'b0;
    keep     = held && req[last_winner] && lock[last_winner];
    limit_c  = keep && (burst_cnt >= BCW'(MAX_BURST - 1));
    if (keep && !limit_c) begin
      winner_c = last_winner;
      locked_c = 1'b1;
    end else if (&req) begin
      // An exhausted burst always hands over, whatever the tie rule.
      if (limit_c) begin
        winner_c = ~last_winner;
      end else begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        winner_c = ~last_winner;
`else
        winner_c = 1'b0;
`endif
      end
    end else begin
      winner_c = req[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port data RAM; registers the winner onto the RAM pins.
// Optional RAM_ARB_ROUND_ROBIN_EN: round-robin on unlocked ties (default: port 0 priority).
module ram_arbiter
  import ram_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_mw,
  input  logic [DW-1:0] ram_rdata
);

  state_t         state;
  logic           last_winner;
  logic [BCW-1:0] burst_cnt;
  logic           acc_port;
  logic           acc_read;
  logic           acc_err;

  logic           any_c, winner_c, locked_c, limit_c;
  logic [AW-1:0]  sel_addr_c;
  logic [DW-1:0]  sel_wdata_c;
  logic           sel_we_c;
  logic           in_range_c;

  ram_arb_pick u_pick (
    .req         ({req1, req0}),
    .lock        ({lock1, lock0}),
    .held        (state == ACCESS),
    .last_winner (last_winner),
    .burst_cnt   (burst_cnt),
    .any_c       (any_c),
    .winner_c    (winner_c),
    .locked_c    (locked_c),
    .limit_c     (limit_c)
  );

  assign sel_addr_c  = winner_c ? addr1  : addr0;
  assign sel_wdata_c = winner_c ? wdata1 : wdata0;
  assign sel_we_c    = winner_c ? we1    : we0;
  assign in_range_c  = sel_addr_c < AW'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      burst_cnt   <= '0;
      acc_port    <= 1'b0;
      acc_read    <= 1'b0;
      acc_err     <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      ram_addr    <= '0;
      ram_data    <= '0;
      ram_mw      <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      ram_mw  <= 1'b0;

      // Complete the access presented to the RAM during the cycle now ending.
      if (state == ACCESS) begin
        if (acc_read) begin
          if (acc_port == 1'(P_LDR)) begin
            rdata1  <= ram_rdata;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= ram_rdata;
            rvalid0 <= 1'b1;
          end
        end
        if (acc_err) begin
          if (acc_port == 1'(P_LDR)) err1 <= 1'b1;
          else                       err0 <= 1'b1;
        end
      end

      if (any_c) begin
        state       <= ACCESS;
        gnt0        <= ~winner_c;
        gnt1        <= winner_c;
        ram_addr    <= in_range_c ? sel_addr_c : '0;
        ram_data    <= sel_wdata_c;
        ram_mw      <= sel_we_c & in_range_c;
        acc_port    <= winner_c;
        acc_read    <= ~sel_we_c & in_range_c;
        acc_err     <= ~in_range_c;
        last_winner <= winner_c;
        if (locked_c)                                burst_cnt <= burst_cnt + BCW'(1);
        else if (limit_c && winner_c == last_winner) burst_cnt <= burst_cnt;
        else                                         burst_cnt <= '0;
      end else begin
        state     <= IDLE;
        acc_read  <= 1'b0;
        acc_err   <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

endmodule
